branch_redirect_unit: RTL and testbench
=======================================

# branch_redirect_unit

Fetch-side PC generator and branch-resolution unit. It owns `pc_F`, which drives instruction memory and the PHT lookup. It tracks each fetched instruction's prediction through D and E, and compares it with the outcome resolved in E. It also issues the redirect and flush on a mispredict, and forwards valid-gated update strobes to the PHT.

## Interface
- `PC_W`, 20, PC width in bits.
- `RESET_PC`, 20'h00000, value of `pc_F` after reset.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall_F` in 1: hold `pc_F`.
- `stall_D` in 1: hold the F/D register and insert a bubble into E. The hazard unit asserts `stall_F` whenever it asserts `stall_D`.
- `predict_F` in 2: PHT counter for `pc_F`; bit 1 means predict taken.
- `btb_hit_F` in 1: a target is available for `pc_F`.
- `btb_target_F` in PC_W: the predicted target.
- `branch_E` in 1: E holds a conditional branch.
- `jump_E` in 1: E holds a jump.
- `take_E` in 1: branch condition result.
- `target_E` in PC_W: resolved target.
- `pc_F`, `pc_D`, `pc_E` out PC_W: stage PCs.
- `mispredict` out 1: E outcome differs from the prediction.
- `flush_D`, `flush_E` out 1: equal to `mispredict`; they squash the external D and E registers.
- `pht_branch_E`, `pht_jump_E` out 1: equal to `valid_E & branch_E` and `valid_E & jump_E`.
- `branch_cnt`, `mispredict_cnt` out 32: performance counters; see Configuration.

## Operation
- F prediction: `pred_F = predict_F[1] & btb_hit_F`.
- Sequential next PC: `seq = pc_F + 4`, modulo 2^PC_W (20'hFFFFC wraps to 0).
- F/D register holds `{pc_D, valid_D, pred_D, ptgt_D}`. D/E register holds `{pc_E, valid_E, pred_E, ptgt_E}`. `ptgt` is `btb_target_F`, captured at fetch.
- Actual direction: `act = jump_E | take_E`.
- `mispredict` is 1 when `valid_E` and any of these holds:
  - `branch_E|jump_E` and `act != pred_E`.
  - `branch_E|jump_E` and `act & pred_E & (target_E != ptgt_E)`.
  - `!branch_E & !jump_E & pred_E` (a non-branch was predicted taken).
- Redirect PC: `act & (branch_E|jump_E) ? target_E : pc_E + 4`.
- Next-state priority, highest first:
  1. **mispredict:** `pc_F <= redirect`; `valid_D <= 0`; `valid_E <= 0`. This overrides both stalls.
  2. **stall_D:** `pc_F` and F/D hold; `valid_E <= 0`.
  3. **stall_F only:** `pc_F` holds; `valid_D <= 0`; D advances into E.
  4. **otherwise:** `pc_F <= pred_F ? btb_target_F : seq`; F→D and D→E advance, with `valid_D <= 1`.
- When `valid_E = 0`, `branch_E`, `jump_E` and `take_E` are ignored: no mispredict, no PHT strobe, no count.
- Reset values: `pc_F = RESET_PC`; `pc_D = pc_E = 0`; all valid and pred bits 0; `ptgt = 0`; counters 0. With all valids 0, `mispredict`, `flush_*` and `pht_*` are 0.
- Reset asserted mid-operation discards in-flight state immediately (asynchronous).

## Timing
- `pc_F`, `pc_D` and `pc_E` are registered.
- `mispredict`, `flush_*`, `pht_*` and the redirect PC are combinational from E inputs in the same cycle.
- The redirect appears on `pc_F` one cycle after `mispredict`.
- Mispredict penalty: 2 bubbles, in D and in E.
- Correctly predicted taken branch: target fetched the cycle after the branch is in F, with 0 bubbles.
- `predict_F` and `btb_*` must be valid in the same cycle as `pc_F` (combinational lookup).

## Configuration
- `BP_PERF_CNT_EN` defined:
  - `branch_cnt` increments once for each cycle with `valid_E & (branch_E|jump_E)`.
  - `mispredict_cnt` increments once for each cycle with `mispredict`.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- **Reset:** assert `rst` mid-stream → `pc_F = RESET_PC` immediately; `mispredict = 0`. After release, `pc_F` steps 0, 4, 8.
- **Predicted taken, correct:** `pc_F = 0x40`, `predict_F = 2'b10`, `btb_hit_F = 1`, target `0x100`.
  - Next cycle: `pc_F = 0x100`.
  - Two cycles later, E has `branch_E = 1`, `take_E = 1`, `target_E = 0x100` → `mispredict = 0`, `pht_branch_E = 1`.
- **Predicted not taken, actually taken:** `branch_E = 1`, `take_E = 1`, `target_E = 0x200` → `mispredict = flush_D = flush_E = 1`. Next cycle `pc_F = 0x200`, `valid_D = valid_E = 0`.
- **Predicted taken, not taken:** `pc_E = 0x80`, `take_E = 0` → redirect to `0x84`. Same for a non-branch predicted taken.
- **Stall vs. mispredict:** `stall_F = stall_D = 1` in the same cycle as a mispredict → redirect wins and `pc_F` takes the new value. `stall_F` alone for 3 cycles → `pc_F` held; one bubble reaches E.
- **Wrap and counters:** `pc_F = 20'hFFFFC` → next `0`. With `BP_PERF_CNT_EN`, run 5 branches with 2 mispredicts → `branch_cnt = 5`, `mispredict_cnt = 2`.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
// Fetch-side PC generator and branch-resolution unit. Owns pc_F, carries each
// fetched instruction's prediction through D and E, checks it against the
// outcome resolved in E, and redirects/flushes on a mispredict.
// Optional feature macro: BP_PERF_CNT_EN builds saturating 32-bit branch and
// mispredict counters; without it both counter outputs are tied to zero.
module branch_redirect_unit #(
    parameter int unsigned     PC_W     = 20,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_F,
    input  logic            stall_D,
    input  logic [1:0]      predict_F,
    input  logic            btb_hit_F,
    input  logic [PC_W-1:0] btb_target_F,
    input  logic            branch_E,
    input  logic            jump_E,
    input  logic            take_E,
    input  logic [PC_W-1:0] target_E,
    output logic [PC_W-1:0] pc_F,
    output logic [PC_W-1:0] pc_D,
    output logic [PC_W-1:0] pc_E,
    output logic            mispredict,
    output logic            flush_D,
    output logic            flush_E,
    output logic            pht_branch_E,
    output logic            pht_jump_E,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    // Fetch-stage PC
    logic [PC_W-1:0] r_pc_F;

    // F/D pipeline register
    logic [PC_W-1:0] r_pc_D;
    logic            r_valid_D;
    logic            r_pred_D;
    logic [PC_W-1:0] r_ptgt_D;

    // D/E pipeline register
    logic [PC_W-1:0] r_pc_E;
    logic            r_valid_E;
    logic            r_pred_E;
    logic [PC_W-1:0] r_ptgt_E;

    logic            w_pred_F;
    logic [PC_W-1:0] w_seq_F;
    logic            w_cti_E;
    logic            w_act_E;
    logic            w_mispredict;
    logic [PC_W-1:0] w_redirect;

    // Only the direction bit of the PHT counter matters here; the low bit
    // is consumed by the PHT update logic outside this block.
    logic            w_unused_predict_lsb;
    assign w_unused_predict_lsb = predict_F[0];

    // Fetch-side prediction: taken only when the PHT says so and a target exists
    assign w_pred_F = predict_F[1] & btb_hit_F;
    assign w_seq_F  = r_pc_F + PC_STEP;   // wraps naturally at 2^PC_W

    // E-stage resolution
    assign w_cti_E = branch_E | jump_E;
    assign w_act_E = jump_E | take_E;

    // Compare the prediction carried into E with the resolved outcome
    always_comb begin
        w_mispredict = 1'b0;
        if (r_valid_E) begin
            if (w_cti_E) begin
                w_mispredict = (w_act_E != r_pred_E) |
                               (w_act_E & r_pred_E & (target_E != r_ptgt_E));
            end else begin
                // A non-branch that fetch steered to a BTB target
                w_mispredict = r_pred_E;
            end
        end
    end

    // Not-taken (or non-branch) redirect resumes at the fall-through address
    assign w_redirect = (w_act_E & w_cti_E) ? target_E : (r_pc_E + PC_STEP);

    // pc_F: redirect beats both stalls, otherwise follow the prediction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_F <= RESET_PC;
        end else if (w_mispredict) begin
            r_pc_F <= w_redirect;
        end else if (!stall_F && !stall_D) begin
            r_pc_F <= w_pred_F ? btb_target_F : w_seq_F;
        end
    end

    // F/D register: squash on mispredict, hold on stall_D, bubble on stall_F
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_D    <= '0;
            r_valid_D <= 1'b0;
            r_pred_D  <= 1'b0;
            r_ptgt_D  <= '0;
        end else if (w_mispredict) begin
            r_valid_D <= 1'b0;
        end else if (stall_D) begin
            r_valid_D <= r_valid_D;
        end else if (stall_F) begin
            r_valid_D <= 1'b0;
        end else begin
            r_pc_D    <= r_pc_F;
            r_valid_D <= 1'b1;
            r_pred_D  <= w_pred_F;
            r_ptgt_D  <= btb_target_F;
        end
    end

    // D/E register: bubble on mispredict or stall_D, otherwise take D
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_E    <= '0;
            r_valid_E <= 1'b0;
            r_pred_E  <= 1'b0;
            r_ptgt_E  <= '0;
        end else if (w_mispredict || stall_D) begin
            r_valid_E <= 1'b0;
        end else begin
            r_pc_E    <= r_pc_D;
            r_valid_E <= r_valid_D;
            r_pred_E  <= r_pred_D;
            r_ptgt_E  <= r_ptgt_D;
        end
    end

    assign pc_F         = r_pc_F;
    assign pc_D         = r_pc_D;
    assign pc_E         = r_pc_E;
    assign mispredict   = w_mispredict;
    assign flush_D      = w_mispredict;
    assign flush_E      = w_mispredict;
    assign pht_branch_E = r_valid_E & branch_E;
    assign pht_jump_E   = r_valid_E & jump_E;

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    // Saturating count of resolved control-transfer instructions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt <= '0;
        end else if (r_valid_E && w_cti_E && (r_branch_cnt != 32'hFFFF_FFFF)) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
        end
    end

    // Saturating count of mispredict cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispredict_cnt <= '0;
        end else if (w_mispredict && (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
`else
    assign branch_cnt     = 32'd0;
    assign mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed test-plan steps
// followed by randomized cycles, all checked against a transaction-level
// model of the fetch pipeline (one slot per stage).
module tb_branch_redirect_unit;

    localparam int PC_W = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall_F, stall_D;
    logic [1:0]      predict_F;
    logic            btb_hit_F;
    logic [PC_W-1:0] btb_target_F;
    logic            branch_E, jump_E, take_E;
    logic [PC_W-1:0] target_E;
    logic [PC_W-1:0] pc_F, pc_D, pc_E;
    logic            mispredict, flush_D, flush_E, pht_branch_E, pht_jump_E;
    logic [31:0]     branch_cnt, mispredict_cnt;

    branch_redirect_unit #(.PC_W(PC_W), .RESET_PC(20'h00000)) dut (
        .clk(clk), .rst(rst),
        .stall_F(stall_F), .stall_D(stall_D),
        .predict_F(predict_F), .btb_hit_F(btb_hit_F), .btb_target_F(btb_target_F),
        .branch_E(branch_E), .jump_E(jump_E), .take_E(take_E), .target_E(target_E),
        .pc_F(pc_F), .pc_D(pc_D), .pc_E(pc_E),
        .mispredict(mispredict), .flush_D(flush_D), .flush_E(flush_E),
        .pht_branch_E(pht_branch_E), .pht_jump_E(pht_jump_E),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    // One in-flight instruction: valid, fetch PC, predicted-taken, predicted target
    typedef struct packed {
        logic            v;
        logic [PC_W-1:0] pc;
        logic            p;
        logic [PC_W-1:0] t;
    } slot_t;

    slot_t           m_D, m_E;
    logic [PC_W-1:0] m_pcF;
    logic [31:0]     m_bcnt, m_mcnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pcF  = 20'h00000;
        m_D    = '0;
        m_E    = '0;
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    task automatic idle();
        stall_F = 0; stall_D = 0;
        predict_F = 2'b00; btb_hit_F = 0; btb_target_F = '0;
        branch_E = 0; jump_E = 0; take_E = 0; target_E = '0;
    endtask

    task automatic set_f(input logic [1:0] p, input logic h, input logic [PC_W-1:0] t);
        predict_F = p; btb_hit_F = h; btb_target_F = t;
    endtask

    task automatic set_e(input logic b, input logic j, input logic k, input logic [PC_W-1:0] t);
        branch_E = b; jump_E = j; take_E = k; target_E = t;
    endtask

    // Did the instruction in E go somewhere other than where fetch sent it?
    function automatic logic model_mp();
        logic act;
        act = jump_E | take_E;
        if (!m_E.v) return 1'b0;
        if (branch_E | jump_E) return (act != m_E.p) || (act && m_E.p && target_E != m_E.t);
        return m_E.p;
    endfunction

    function automatic logic [PC_W-1:0] model_redirect();
        if ((jump_E | take_E) && (branch_E | jump_E)) return target_E;
        return m_E.pc + 20'd4;
    endfunction

    function automatic logic [31:0] exp_bcnt();
`ifdef BP_PERF_CNT_EN
        return m_bcnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_mcnt();
`ifdef BP_PERF_CNT_EN
        return m_mcnt;
`else
        return 32'd0;
`endif
    endfunction

    // Let inputs settle, then compare every output against the model
    task automatic eval();
        logic mp;
        #2;
        mp = model_mp();
        chk("pc_F", pc_F, m_pcF);
        if (m_D.v) chk("pc_D", pc_D, m_D.pc);
        if (m_E.v) chk("pc_E", pc_E, m_E.pc);
        chk("mispredict", mispredict, mp);
        chk("flush_D", flush_D, mp);
        chk("flush_E", flush_E, mp);
        chk("pht_branch_E", pht_branch_E, m_E.v & branch_E);
        chk("pht_jump_E", pht_jump_E, m_E.v & jump_E);
        chk("branch_cnt", branch_cnt, exp_bcnt());
        chk("mispredict_cnt", mispredict_cnt, exp_mcnt());
        $display("vec t=%0t pc_F=%h stallF=%b stallD=%b br=%b jp=%b tk=%b tgtE=%h mp=%b",
                 $time, pc_F, stall_F, stall_D, branch_E, jump_E, take_E, target_E, mispredict);
    endtask

    // Advance the model across one rising edge, then idle the inputs
    task automatic tick();
        logic            mp, pf;
        logic [PC_W-1:0] rd;
        slot_t           f;
        mp = model_mp();
        rd = model_redirect();
        pf = predict_F[1] & btb_hit_F;
        f  = '{v: 1'b1, pc: m_pcF, p: pf, t: btb_target_F};
        if (m_E.v && (branch_E | jump_E) && m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        if (mp && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
        if (mp) begin
            m_pcF = rd; m_D.v = 0; m_E.v = 0;
        end else if (stall_D) begin
            m_E.v = 0;
        end else if (stall_F) begin
            m_E = m_D; m_D.v = 0;
        end else begin
            m_E = m_D; m_D = f;
            m_pcF = pf ? btb_target_F : m_pcF + 20'd4;
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic cycle();
        eval();
        tick();
    endtask

    // Assert reset between edges and check that it takes effect at once
    task automatic async_reset();
        #2;
        rst = 1;
        #1;
        chk("rst_pc_F", pc_F, 20'h00000);
        chk("rst_mispredict", mispredict, 1'b0);
        chk("rst_pht_branch", pht_branch_E, 1'b0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispredict_cnt", mispredict_cnt, 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    logic [PC_W-1:0] held_pc;
    int              nbr;

    initial begin
        rst = 1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc_F", pc_F, 20'h00000);
        chk("reset_pc_D", pc_D, 20'h00000);
        chk("reset_pc_E", pc_E, 20'h00000);
        chk("reset_mispredict", mispredict, 1'b0);
        chk("reset_pht_jump", pht_jump_E, 1'b0);
        rst = 0;

        // A short run, then reset mid-stream with an E outcome that would otherwise mispredict
        repeat (4) cycle();
        set_e(1, 0, 1, 20'h12340);
        async_reset();

        // Sequential fetch after release
        chk("seq0", pc_F, 20'h00000); cycle();
        chk("seq4", pc_F, 20'h00004); cycle();
        chk("seq8", pc_F, 20'h00008);

        // Predicted taken, correct: 8 -> 0x40 -> 0x100
        set_f(2'b10, 1, 20'h00040); cycle();
        chk("pt_pc40", pc_F, 20'h00040);
        set_f(2'b11, 1, 20'h00100); cycle();
        chk("pt_pc100", pc_F, 20'h00100);
        set_e(1, 0, 1, 20'h00040); cycle();          // E: pc 8, predicted taken to 0x40
        set_e(1, 0, 1, 20'h00100); eval();           // E: pc 0x40, predicted taken to 0x100
        chk("pt_no_mp", mispredict, 1'b0);
        chk("pt_pht", pht_branch_E, 1'b1);
        tick();

        // Predicted not taken, actually taken to 0x200
        set_e(1, 0, 1, 20'h00200); eval();           // E: pc 0x100, predicted not taken
        chk("nt_mp", mispredict, 1'b1);
        chk("nt_flushD", flush_D, 1'b1);
        chk("nt_flushE", flush_E, 1'b1);
        tick();
        chk("nt_redirect", pc_F, 20'h00200);
        set_f(2'b10, 1, 20'h00080);
        set_e(1, 0, 1, 20'h00999); eval();           // E squashed: outcome ignored
        chk("nt_bubbleE_mp", mispredict, 1'b0);
        chk("nt_bubbleE_pht", pht_branch_E, 1'b0);
        tick();
        set_f(2'b10, 1, 20'h00300);
        set_e(1, 0, 1, 20'h00999); eval();           // second bubble from squashed D
        chk("nt_bubbleD_pht", pht_branch_E, 1'b0);
        tick();

        // Jump correctly predicted, then predicted-taken branch not taken at 0x80
        set_e(0, 1, 0, 20'h00080); eval();
        chk("jmp_pht", pht_jump_E, 1'b1);
        chk("jmp_no_mp", mispredict, 1'b0);
        tick();
        set_e(1, 0, 0, 20'h00300); eval();
        chk("tn_mp", mispredict, 1'b1);
        tick();
        chk("tn_redirect", pc_F, 20'h00084);

        // Non-branch predicted taken at 0x84
        set_f(2'b10, 1, 20'h00400); cycle();
        cycle();
        eval();
        chk("nb_mp", mispredict, 1'b1);
        tick();
        chk("nb_redirect", pc_F, 20'h00088);

        // Mispredict coinciding with both stalls: redirect wins
        cycle(); cycle();
        stall_F = 1; stall_D = 1;
        set_e(1, 0, 1, 20'h00500); eval();
        chk("stall_mp", mispredict, 1'b1);
        tick();
        chk("stall_redirect", pc_F, 20'h00500);

        // stall_F alone for three cycles: pc_F held, a bubble drains into E
        cycle(); cycle();
        held_pc = pc_F;
        for (int i = 0; i < 3; i++) begin
            stall_F = 1;
            if (i == 2) set_e(1, 0, 1, 20'h00777);
            eval();
            if (i == 2) chk("stallF_bubble_pht", pht_branch_E, 1'b0);
            tick();
            chk("stallF_hold", pc_F, held_pc);
        end

        // Wrap at the top of the address space
        cycle(); cycle();
        set_e(0, 1, 1, 20'hFFFFC); cycle();
        chk("wrap_top", pc_F, 20'hFFFFC);
        cycle();
        chk("wrap_zero", pc_F, 20'h00000);

        // Counters: five branches, the last two mispredicted
        async_reset();
        nbr = 0;
        for (int g = 0; g < 40 && nbr < 5; g++) begin
            if (m_E.v) begin
                case (nbr)
                    3:       set_e(1, 0, 1, 20'h00020);
                    4:       set_e(1, 0, 1, 20'h00040);
                    default: set_e(1, 0, 0, 20'h00000);
                endcase
                nbr++;
            end
            cycle();
        end
        chk("cnt_branches_issued", nbr, 5);
`ifdef BP_PERF_CNT_EN
        chk("cnt_branch5", branch_cnt, 32'd5);
        chk("cnt_mispredict2", mispredict_cnt, 32'd2);
`else
        chk("cnt_branch_tied", branch_cnt, 32'd0);
        chk("cnt_mispredict_tied", mispredict_cnt, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall_D = ($urandom_range(0, 9) == 0);
            stall_F = stall_D | ($urandom_range(0, 7) == 0);
            set_f(2'($urandom), 1'($urandom), {18'($urandom), 2'b00});
            case ($urandom_range(0, 3))
                0: set_e(0, 0, 1'($urandom), '0);
                1: set_e(0, 1, 1'($urandom), '0);
                default: set_e(1, 0, 1'($urandom), '0);
            endcase
            if (m_E.v && $urandom_range(0, 1) == 1) target_E = m_E.t;
            else target_E = {18'($urandom), 2'b00};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
